lsb_embed_stream: RTL and testbench

//  Parametrised LSB steganography embedder. Buffers secret-message bytes in an internal FIFO
//  and embeds 1..MAX_NBITS message bits per colour channel into a streamed multi-channel pixel
//  bus. Pixels after the message ends pass through unmodified.

---
 rtl/lsb_embed_stream_if.sv | 11 +
 rtl/lsb_embed_stream.sv | 192 +++++++++++++++++++
 tb/tb_lsb_embed_stream.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsb_embed_stream_if.sv
// Valid/ready pixel stream used on both sides of the LSB embedder.
interface lsb_embed_stream_if #(
  parameter int W = 24
) ();
  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lsb_embed_stream.sv
// LSB steganography embedder: message bytes are buffered in a FIFO, unpacked through a
// bit reservoir and written MSB-first into the low bits of each colour channel.
//   state | meaning
//   IDLE  | waiting for start, pixels blocked
//   EMBED | replacing LSBs until every message bit has been placed
//   PASS  | pixels copied unchanged until reset or start
module lsb_embed_stream #(
  parameter int PIX_W     = 8,
  parameter int CHANNELS  = 3,
  parameter int MAX_NBITS = 4,
  parameter int DEPTH     = 16
) (
  input  logic               clk,
  input  logic               HRESETn,
  input  logic               start,
  input  logic [2:0]         cfg_nbits,
  input  logic [15:0]        msg_len,
  input  logic               write_enable,
  input  logic [7:0]         Secret_message,
  output logic               full_flag,
  lsb_embed_stream_if.slave  pix,
  lsb_embed_stream_if.master stego,
  output logic               busy,
  output logic               done,
  output logic               underrun
);
  localparam int DW  = CHANNELS * PIX_W;
  localparam int RW  = 8 + CHANNELS * MAX_NBITS;
  localparam int CW  = $clog2(RW + 1);
  localparam int RIW = $clog2(RW);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] MAXN = 3'(MAX_NBITS);

  typedef enum logic [1:0] {IDLE, EMBED, PASS} state_t;
  state_t state_q, state_d;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fcnt_q;
  logic [7:0]    fifo_head;
  logic          fifo_wr, fifo_pop, fifo_empty;

  logic [RW-1:0] res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d, take;
  logic [18:0]   rem_q, rem_d, need, take_w;
  logic [15:0]   left_q;
  logic [2:0]    nbits_q;
  logic          rdy, accept, consume, last, bits_ok, latch_cfg, stall_empty;
  logic [DW-1:0] embed_data;
  int            nb, tk, idx;

  assign fifo_empty = (fcnt_q == '0);
  assign full_flag  = (fcnt_q == (AW+1)'(DEPTH));
  assign fifo_wr    = write_enable & ~full_flag;
  assign fifo_head  = mem[rd_ptr_q];
  // Top up the reservoir only while a whole byte still fits and bytes are owed.
  assign fifo_pop   = (left_q != '0) & ~fifo_empty & (cnt_q <= CW'(RW - 8));

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q] <= Secret_message;
  end

  always_ff @(posedge clk) begin
    if (HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (fifo_wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_wr, fifo_pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    need   = 19'(CHANNELS) * 19'(nbits_q);
    take_w = (rem_q < need) ? rem_q : need;
    take   = CW'(take_w);
  end

  always_ff @(posedge clk) begin
    if (HRESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rdy       = 1'b0;
    latch_cfg = 1'b0;
    last      = 1'b0;
    bits_ok   = (cnt_q >= take);
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_cfg = 1'b1;
          state_d   = (msg_len != '0) ? EMBED : PASS;
        end
      end
      EMBED: begin
        rdy = (~stego.valid | stego.ready) & bits_ok;
        if (pix.valid & rdy & (rem_q == take_w)) begin
          last    = 1'b1;
          state_d = PASS;
        end
      end
      PASS: begin
        rdy = ~stego.valid | stego.ready;
        if (start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pix.ready   = rdy;
  assign accept      = pix.valid & rdy;
  assign consume     = accept & (state_q == EMBED);
  assign stall_empty = (state_q == EMBED) & pix.valid & ~bits_ok & fifo_empty & (left_q != '0);
  assign busy        = (state_q != IDLE);

  // Stream bit i lives at res_q[RW-1-i]; channel c takes bits c*nb .. c*nb+nb-1.
  always_comb begin
    embed_data = pix.data;
    nb  = int'(nbits_q);
    tk  = int'(take);
    idx = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int b = 0; b < MAX_NBITS; b++) begin
        idx = c * nb + nb - 1 - b;
        if (b < nb && idx >= 0 && idx < tk)
          embed_data[c*PIX_W + b] = res_q[RIW'(RW - 1 - idx)];
      end
    end
  end

  always_comb begin
    rem_d = rem_q;
    res_d = res_q;
    cnt_d = cnt_q;
    if (latch_cfg) begin
      rem_d = {msg_len, 3'b000};
      res_d = '0;
      cnt_d = '0;
    end else begin
      if (consume) begin
        rem_d = rem_q - take_w;
        res_d = res_q << take;
        cnt_d = cnt_q - take;
      end
      if (fifo_pop) begin
        res_d = res_d | (RW'(fifo_head) << (CW'(RW - 8) - cnt_d));
        cnt_d = cnt_d + CW'(8);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (HRESETn) begin
      res_q       <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      left_q      <= '0;
      nbits_q     <= MAXN;
      stego.valid <= 1'b0;
      stego.data  <= '0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      res_q <= res_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      done  <= last;
      if (latch_cfg) begin
        nbits_q <= (cfg_nbits == 3'd0 || cfg_nbits > MAXN) ? MAXN : cfg_nbits;
        left_q  <= msg_len;
      end else if (fifo_pop) begin
        left_q <= left_q - 1'b1;
      end
      if (accept) begin
        stego.valid <= 1'b1;
        stego.data  <= (state_q == EMBED) ? embed_data : pix.data;
      end else if (stego.ready) begin
        stego.valid <= 1'b0;
      end
      if (start && state_q != EMBED) underrun <= 1'b0;
      else if (stall_empty)          underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lsb_embed_stream.sv
// Directed bench for lsb_embed_stream: vector table of whole-image cases plus stall/reset sequences.
`timescale 1ns/1ps
module tb_lsb_embed_stream;
  localparam int DW = 24;

  logic        clk = 1'b0;
  logic        HRESETn = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  cfg_nbits = '0;
  logic [15:0] msg_len = '0;
  logic        write_enable = 1'b0;
  logic [7:0]  Secret_message = '0;
  logic        full_flag, busy, done, underrun;

  lsb_embed_stream_if #(.W(DW)) pix_if ();
  lsb_embed_stream_if #(.W(DW)) out_if ();

  lsb_embed_stream #(.PIX_W(8), .CHANNELS(3), .MAX_NBITS(4), .DEPTH(4)) dut (
    .clk(clk), .HRESETn(HRESETn), .start(start), .cfg_nbits(cfg_nbits), .msg_len(msg_len),
    .write_enable(write_enable), .Secret_message(Secret_message), .full_flag(full_flag),
    .pix(pix_if), .stego(out_if), .busy(busy), .done(done), .underrun(underrun));

  always #5 clk = ~clk;

  logic [DW-1:0] obs [$];
  int done_cnt = 0;
  int done_at  = -1;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_at = obs.size();
    end
    if (out_if.valid && out_if.ready) obs.push_back(out_if.data);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    HRESETn = 1'b1;
    pix_if.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 HRESETn = 1'b0;
  endtask

  task automatic wr(input logic [7:0] b);
    write_enable = 1'b1;
    Secret_message = b;
    @(posedge clk);
    #1 write_enable = 1'b0;
  endtask

  task automatic go(input logic [2:0] n, input logic [15:0] len);
    start = 1'b1;
    cfg_nbits = n;
    msg_len = len;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input string tag);
    int t = 0;
    pix_if.valid = 1'b1;
    pix_if.data  = d;
    @(negedge clk);
    while (!pix_if.ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!pix_if.ready) begin
      n_chk++;
      $display("FAIL %s accept: pix_ready stayed 0 for 100 cycles, expected 1", tag);
      pix_if.valid = 1'b0;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    pix_if.valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int base, input int n, input logic [DW-1:0] e [8]);
    chk($sformatf("%s out count", tag), 32'(obs.size() - base), 32'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s px%0d", tag, i),
          (base + i < obs.size()) ? 32'(obs[base + i]) : 32'hxxxxxxxx, 32'(e[i]));
  endtask

  typedef struct {
    logic [2:0]    nbits;
    logic [15:0]   len;
    int            nbytes;
    logic [7:0]    m0, m1;
    logic [DW-1:0] pix;
    int            npix;
    logic [DW-1:0] e0, e1, e2, e3;
    int            done_idx;
  } vec_t;

  vec_t tv [6];
  logic [DW-1:0] e [8];
  int base, dbase;

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time, expected completion");
    $fatal(1);
  end

  initial begin
    tv[0] = '{3'd1, 16'd1, 1, 8'h48, 8'h00, 24'hFFFFFF, 4, 24'hFEFFFE, 24'hFEFFFE, 24'hFFFEFE, 24'hFFFFFF, 2};
    tv[1] = '{3'd2, 16'd1, 1, 8'h48, 8'h00, 24'h000000, 3, 24'h020001, 24'h000000, 24'h000000, 24'h000000, 1};
    tv[2] = '{3'd0, 16'd1, 1, 8'hA5, 8'h00, 24'hFFFFFF, 2, 24'hFFF5FA, 24'hFFFFFF, 24'h0, 24'h0, 0};
    tv[3] = '{3'd7, 16'd2, 2, 8'h3C, 8'h96, 24'h808080, 3, 24'h898C83, 24'h808086, 24'h808080, 24'h0, 1};
    tv[4] = '{3'd1, 16'd0, 0, 8'h00, 8'h00, 24'h123456, 2, 24'h123456, 24'h123456, 24'h0, 24'h0, -1};
    tv[5] = '{3'd3, 16'd1, 1, 8'hB4, 8'h00, 24'hFFFFFF, 2, 24'hF9FDFD, 24'hFFFFFF, 24'h0, 24'h0, 0};

    pix_if.valid = 1'b0;
    pix_if.data  = '0;
    out_if.ready = 1'b1;

    do_reset();
    @(negedge clk);
    chk("reset full_flag", 32'(full_flag), 0);
    chk("reset pix_ready", 32'(pix_if.ready), 0);
    chk("reset out_valid", 32'(out_if.valid), 0);
    chk("reset out_data", 32'(out_if.data), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset underrun", 32'(underrun), 0);
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      do_reset();
      base = obs.size();
      dbase = done_cnt;
      if (tv[k].nbytes > 0) wr(tv[k].m0);
      if (tv[k].nbytes > 1) wr(tv[k].m1);
      go(tv[k].nbits, tv[k].len);
      chk($sformatf("vec%0d busy", k), 32'(busy), 1);
      for (int i = 0; i < tv[k].npix; i++) send(tv[k].pix, $sformatf("vec%0d", k));
      idle(4);
      e = '{tv[k].e0, tv[k].e1, tv[k].e2, tv[k].e3, 24'h0, 24'h0, 24'h0, 24'h0};
      check_outs($sformatf("vec%0d", k), base, tv[k].npix, e);
      chk($sformatf("vec%0d done count", k), 32'(done_cnt - dbase), (tv[k].done_idx >= 0) ? 1 : 0);
      if (tv[k].done_idx >= 0)
        chk($sformatf("vec%0d done index", k), 32'(done_at - base), 32'(tv[k].done_idx));
      chk($sformatf("vec%0d underrun", k), 32'(underrun), 0);
    end

    // FIFO fills at 4, fifth byte dropped: embedding stalls after exactly 4 bytes.
    do_reset();
    base = obs.size();
    dbase = done_cnt;
    wr(8'hA1); wr(8'hB2); wr(8'hC3);
    chk("T3 full after 3", 32'(full_flag), 0);
    wr(8'hD4);
    chk("T3 full after 4", 32'(full_flag), 1);
    wr(8'hE5);
    chk("T3 full after dropped 5th", 32'(full_flag), 1);
    go(3'd4, 16'd5);
    send(24'h0, "T3"); send(24'h0, "T3");
    pix_if.valid = 1'b1;
    pix_if.data = 24'h0;
    repeat (6) @(negedge clk);
    chk("T3 stall pix_ready", 32'(pix_if.ready), 0);
    chk("T3 underrun", 32'(underrun), 1);
    wr(8'h5E);
    send(24'h0, "T3"); send(24'h0, "T3");
    idle(4);
    e = '{24'h0B010A, 24'h030C02, 24'h05040D, 24'h00000E, 24'h0, 24'h0, 24'h0, 24'h0};
    check_outs("T3", base, 4, e);
    chk("T3 done index", 32'(done_at - base), 3);
    chk("T3 done count", 32'(done_cnt - dbase), 1);

    // Downstream back-pressure for 5 cycles mid-stream.
    do_reset();
    base = obs.size();
    dbase = done_cnt;
    wr(8'h48);
    go(3'd1, 16'd1);
    send(24'hFFFFFF, "T5");
    out_if.ready = 1'b0;
    pix_if.valid = 1'b1;
    pix_if.data = 24'hFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("T5 hold%0d out_valid", i), 32'(out_if.valid), 1);
      chk($sformatf("T5 hold%0d out_data", i), 32'(out_if.data), 32'h00FEFFFE);
      chk($sformatf("T5 hold%0d pix_ready", i), 32'(pix_if.ready), 0);
    end
    @(posedge clk);
    #1 out_if.ready = 1'b1;
    send(24'hFFFFFF, "T5"); send(24'hFFFFFF, "T5"); send(24'h0F0F0F, "T5");
    idle(4);
    e = '{24'hFEFFFE, 24'hFEFFFE, 24'hFFFEFE, 24'h0F0F0F, 24'h0, 24'h0, 24'h0, 24'h0};
    check_outs("T5", base, 4, e);
    chk("T5 done index", 32'(done_at - base), 2);

    // FIFO runs dry mid-message; the second byte resumes embedding with no bit lost.
    do_reset();
    base = obs.size();
    dbase = done_cnt;
    wr(8'h48);
    go(3'd1, 16'd2);
    send(24'h0, "T4"); send(24'h0, "T4");
    pix_if.valid = 1'b1;
    pix_if.data = 24'h0;
    repeat (5) @(negedge clk);
    chk("T4 stall pix_ready", 32'(pix_if.ready), 0);
    chk("T4 underrun", 32'(underrun), 1);
    wr(8'hC3);
    for (int i = 0; i < 5; i++) send(24'h0, "T4");
    idle(4);
    e = '{24'h000100, 24'h000100, 24'h010000, 24'h000001, 24'h010000, 24'h000001, 24'h000000, 24'h0};
    check_outs("T4", base, 7, e);
    chk("T4 done index", 32'(done_at - base), 5);
    chk("T4 underrun sticky", 32'(underrun), 1);

    // One-cycle reset in the middle of EMBED with bytes still queued.
    do_reset();
    chk("T6 underrun cleared by reset", 32'(underrun), 0);
    wr(8'h48); wr(8'hC3); wr(8'h11);
    go(3'd1, 16'd4);
    send(24'h0, "T6"); send(24'h0, "T6");
    chk("T6 busy before reset", 32'(busy), 1);
    HRESETn = 1'b1;
    pix_if.valid = 1'b0;
    @(posedge clk);
    #1 HRESETn = 1'b0;
    @(negedge clk);
    chk("T6 full_flag", 32'(full_flag), 0);
    chk("T6 pix_ready", 32'(pix_if.ready), 0);
    chk("T6 out_valid", 32'(out_if.valid), 0);
    chk("T6 out_data", 32'(out_if.data), 0);
    chk("T6 busy", 32'(busy), 0);
    chk("T6 done", 32'(done), 0);
    chk("T6 underrun", 32'(underrun), 0);
    @(posedge clk); #1;
    go(3'd1, 16'd1);
    pix_if.valid = 1'b1;
    pix_if.data = 24'h0;
    repeat (4) @(negedge clk);
    chk("T6 fifo empty stall pix_ready", 32'(pix_if.ready), 0);
    chk("T6 fifo empty underrun", 32'(underrun), 1);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
